// File: rtl/pipe_issue_stage.sv
// Issue stage: instruction FIFO feeding registered decoded fields, with an optional
// read-after-write interlock enabled by defining PIPE_HAZARD_INTERLOCK_EN.
module pipe_issue_stage #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        stall,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        out_valid,
  output logic [7:0]  bubble_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (HAZ_WIN < 1)) begin : g_bad_params
    $error("pipe_issue_stage: DEPTH must be a power of 2 >= 2 and HAZ_WIN >= 1");
  end

  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   out_instr_q, out_instr_d;
  logic          out_valid_q, out_valid_d;

  logic          push_s, issue_s, nonempty_s, hazard_s;
  logic [23:0]   head_s;

  assign in_ready   = (count_q < CW'(DEPTH));
  assign push_s     = in_valid && in_ready;
  assign nonempty_s = (count_q != {CW{1'b0}});
  assign head_s     = mem_q[rd_ptr_q];
  assign issue_s    = !stall && nonempty_s && !hazard_s;

`ifdef PIPE_HAZARD_INTERLOCK_EN
  logic [HAZ_WIN-1:0] hist_v_q, hist_v_d;
  logic [3:0]         hist_rd_q [HAZ_WIN];
  logic [3:0]         hist_rd_d [HAZ_WIN];
  logic [7:0]         bubble_q, bubble_d;

  // Hazard when the head reads a register still being written by a recent issue slot.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (hist_v_q[i] && ((hist_rd_q[i] == head_s[19:16]) || (hist_rd_q[i] == head_s[15:12]))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // History shifts once per unstalled edge; bubble slots enter as invalid.
  always_comb begin
    hist_v_d  = hist_v_q;
    hist_rd_d = hist_rd_q;
    bubble_d  = bubble_q;
    if (!stall) begin
      hist_v_d[0]  = issue_s;
      hist_rd_d[0] = head_s[11:8];
      for (int i = 1; i < HAZ_WIN; i++) begin
        hist_v_d[i]  = hist_v_q[i-1];
        hist_rd_d[i] = hist_rd_q[i-1];
      end
      if (nonempty_s && hazard_s && (bubble_q != 8'hFF)) begin
        bubble_d = bubble_q + 8'd1;
      end else begin
        bubble_d = bubble_q;
      end
    end else begin
      hist_v_d = hist_v_q;
    end
  end

  // Hazard history and bubble counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v_q <= {HAZ_WIN{1'b0}};
      for (int i = 0; i < HAZ_WIN; i++) hist_rd_q[i] <= 4'h0;
      bubble_q <= 8'h00;
    end else begin
      hist_v_q  <= hist_v_d;
      hist_rd_q <= hist_rd_d;
      bubble_q  <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;
`else
  assign hazard_s   = 1'b0;
  assign bubble_cnt = 8'h00;
`endif

  // FIFO write, pointer and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_instr;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, issue_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output fields only change on issue; out_valid drops on unstalled non-issue edges.
  always_comb begin
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    if (issue_s) begin
      out_instr_d = head_s;
      out_valid_d = 1'b1;
    end else if (!stall) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FIFO and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 24'h0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      out_instr_q <= 24'h0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign func      = out_instr_q[23:20];
  assign rs1       = out_instr_q[19:16];
  assign rs2       = out_instr_q[15:12];
  assign rd        = out_instr_q[11:8];
  assign addr      = out_instr_q[7:0];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_issue_stage.sv
// Scoreboard bench for pipe_issue_stage: queue-based reference model plus a
// negedge monitor; follows PIPE_HAZARD_INTERLOCK_EN like the design.
module tb_pipe_issue_stage;

  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 2;
`ifdef PIPE_HAZARD_INTERLOCK_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_instr = 24'h0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        in_ready, out_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, bubble_cnt;

  always #5 clk = ~clk;

  pipe_issue_stage #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .stall(stall), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .out_valid(out_valid), .bubble_cnt(bubble_cnt)
  );

  typedef struct { bit v; logic [3:0] rd; } slot_t;

  logic [23:0] mq[$];
  slot_t       hist[$];
  logic [23:0] exp_q[$];
  logic [23:0] last_m = 24'h0;
  bit          ov_m = 1'b0;
  int          bub_m = 0;
  bit          stall_seen = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [23:0] mk(input int f, input int a, input int b, input int d, input int ad);
    return {f[3:0], a[3:0], b[3:0], d[3:0], ad[7:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < HAZ_WIN; i++) hist.push_back('{1'b0, 4'h0});
    last_m = 24'h0;
    ov_m   = 1'b0;
    bub_m  = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per rising edge, from the rules in plain queue form.
  task automatic model_step();
    bit          acc, haz;
    logic [23:0] h;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = in_valid && (mq.size() < DEPTH);
    if (!stall) begin
      haz = 1'b0;
      if (HAZ_EN && mq.size() > 0)
        foreach (hist[i])
          if (hist[i].v && (hist[i].rd == mq[0][19:16] || hist[i].rd == mq[0][15:12])) haz = 1'b1;
      if (mq.size() == 0) begin
        ov_m = 1'b0;
        hist.push_front('{1'b0, 4'h0});
      end else if (haz) begin
        ov_m = 1'b0;
        if (bub_m < 255) bub_m++;
        hist.push_front('{1'b0, 4'h0});
      end else begin
        h = mq.pop_front();
        exp_q.push_back(h);
        last_m = h;
        ov_m = 1'b1;
        hist.push_front('{1'b1, h[11:8]});
      end
      void'(hist.pop_back());
    end
    if (acc) mq.push_back(in_instr);
  endtask

  task automatic monitor_step();
    logic [23:0] got, want;
    got = {func, rs1, rs2, rd, addr};
    check("out_valid", 32'(out_valid), 32'(ov_m));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check("bubble_cnt", 32'(bubble_cnt), 32'(bub_m));
    check("fields_held", 32'(got), 32'(last_m));
    if (out_valid && !stall_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 32'(got), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check("issue_order", 32'(got), 32'(want));
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      stall_seen = stall;
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic drive(input bit v, input logic [23:0] ins, input bit st);
    in_valid = v;
    in_instr = ins;
    stall    = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 1'b0);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [23:0] ia, ib, ic;

  initial begin
    ia = mk(0, 3, 5, 10, 125);
    ib = mk(2, 3, 8, 12, 126);
    ic = mk(1, 10, 5, 14, 128);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    // back-to-back independent pair
    drive(1'b1, ia, 1'b0);
    drive(1'b1, ib, 1'b0);
    idle(4);
    // dependent pair
    drive(1'b1, ia, 1'b0);
    drive(1'b1, ic, 1'b0);
    idle(5);
    // fill under stall, fifth push refused, then drain
    for (int i = 0; i < 5; i++) drive(1'b1, mk(i, i % 4, (i + 1) % 4, 4 + i, 16 + i), 1'b1);
    idle(7);
    // stall mid-stream
    for (int i = 0; i < 4; i++) drive(1'b1, mk(i + 8, i % 4, 2, 8 + i, 40 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 24'h0, 1'b1);
    idle(6);
    // reset with work queued
    drive(1'b1, ia, 1'b0);
    drive(1'b1, ic, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, mk(3, 1, 2, 3, 60 + i), 1'b1);
    pulse_reset();
    idle(6);
    // bubble counter saturation
    for (int i = 0; i < 140; i++) begin
      drive(1'b1, ia, 1'b0);
      drive(1'b1, ic, 1'b0);
      idle(3);
    end
    // randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else drive($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 4) == 0);
    end
    idle(20);
    check("drain_fifo_empty", 32'(mq.size()), 32'd0);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_issue_stage.md
PIPE_ISSUE_STAGE -- requirements
Module: pipe_issue_stage

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, instruction FIFO entries (power of 2, min 2).
REQ-002 SHALL provide parameter HAZ_WIN, default 2, issue slots checked for read-after-write hazard.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port in_instr  input  24  packed instruction {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}.
REQ-006 SHALL provide port in_valid  input  1  in_instr valid this cycle.
REQ-007 SHALL provide port in_ready  output  1  FIFO can accept; high when not full.
REQ-008 SHALL provide port stall  input  1  downstream freeze request.
REQ-009 SHALL provide ports rs1, rs2, rd, func  output  4 each  registered decoded fields to the register-read stage.
REQ-010 SHALL provide port addr  output  8  registered decoded store address.
REQ-011 SHALL provide port out_valid  output  1  registered; fields carry a real instruction this cycle.
REQ-012 SHALL provide port bubble_cnt  output  8  count of hazard bubbles inserted, saturating.

Function
REQ-013 SHALL accept in_instr on an edge where in_valid and in_ready are both high.
REQ-014 SHALL derive in_ready solely from registered occupancy (count < DEPTH); a pop in the same cycle does not raise in_ready when full.
REQ-015 SHALL preserve FIFO order; pointers wrap modulo DEPTH.
REQ-016 SHALL, on each edge with stall low, pop the head and register its fields with out_valid=1 when the FIFO is non-empty and no hazard is present.
REQ-017 SHALL, with stall low and FIFO empty or hazard present, drive out_valid=0, hold rs1/rs2/rd/func/addr at last values, and not pop.
REQ-018 SHALL, with stall high, hold every output and the hazard history, and not pop; pushes still occur per REQ-013.
REQ-019 SHALL keep a HAZ_WIN-deep history of {valid, rd} for issue slots, shifted on every stall-low edge (bubble slots enter as invalid).
REQ-020 SHALL flag a hazard when head rs1 or rs2 equals rd of any valid history entry.
REQ-021 SHALL increment bubble_cnt by 1 on every stall-low edge where a hazard blocks issue; saturate at 255; empty-FIFO cycles not counted.
REQ-022 SHALL give one-cycle latency: instruction accepted into an empty FIFO on edge t, no hazard, appears with out_valid=1 after edge t+1.
REQ-023 SHALL allow simultaneous push and pop in one cycle, occupancy unchanged.

Reset
REQ-024 SHALL, on rst_n low, immediately clear FIFO pointers and count, history valid bits, bubble_cnt, out_valid, and all field outputs to 0.
REQ-025 SHALL discard all queued instructions on reset mid-operation; in_ready=1 while in reset.

Configuration
REQ-026 SHALL implement hazard interlock (REQ-019..REQ-021) only when macro PIPE_HAZARD_INTERLOCK_EN is defined.
REQ-027 SHALL, without PIPE_HAZARD_INTERLOCK_EN, never flag hazards, issue back-to-back, and tie bubble_cnt to 0.

Verification
REQ-028 SHALL cover: assert rst_n=0 -> all outputs 0, out_valid=0, in_ready=1.
REQ-029 SHALL cover: push A(func0,rs1=3,rs2=5,rd=10,addr=125), B(func2,rs1=3,rs2=8,rd=12,addr=126) back-to-back -> out_valid high two consecutive cycles, fields A then B, bubble_cnt=0.
REQ-030 SHALL cover: push A then C(func1,rs1=10,rs2=5,rd=14,addr=128) -> with macro C issues 3 cycles after A, bubble_cnt=2; without macro C issues next cycle, bubble_cnt=0.
REQ-031 SHALL cover: stall=1, push 4 independent instructions -> in_ready=0 after 4th, 5th push not accepted; release stall -> 4 issue in order on consecutive cycles.
REQ-032 SHALL cover: stall=1 for 3 cycles mid-stream -> all outputs frozen, no pop; stall=0 -> issue resumes with next queued instruction.
REQ-033 SHALL cover: 3 instructions queued, bubble_cnt=2, pulse rst_n low -> count 0, out_valid 0, bubble_cnt 0, no queued instruction issues afterwards.
